hazard_sequencer: RTL and testbench

- Pipeline control block for the 5-stage RV32 core; generates all stall and flush enables for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Sequences multi-cycle multiply/divide operations that occupy EX for MD_LATENCY cycles.
- Detects load-use hazards, which the EX-stage forwarding mux cannot resolve.
- Handles taken-branch/jump flushes.
- Sits beside the forwarding unit and consumes the same decoded register indices.

---
 rtl/hazard_sequencer_if.sv | 33 +++
 rtl/hazard_sequencer.sv | 115 +++++++++++
 tb/tb_hazard_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_if.sv
// Hazard control bundle between the RV32 pipeline datapath and hazard_sequencer.
// The core (master) supplies decoded register indices and EX-stage events; the sequencer (slave) returns stall/flush enables.
interface hazard_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       RdE;
  logic             LoadE;
  logic             PCSrcE;
  logic             MdStartE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic             MdBusy;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCycles;

  modport master (
    output Rs1D, Rs2D, RdE, LoadE, PCSrcE, MdStartE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy,
    input  StallCycles, FlushCycles
  );

  modport slave (
    input  Rs1D, Rs2D, RdE, LoadE, PCSrcE, MdStartE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy,
    output StallCycles, FlushCycles
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Stall/flush generation for the 5-stage RV32 pipeline: mul/div sequencing, load-use and branch flushes.
// Define HAZARD_PERF_EN to build the saturating StallCycles/FlushCycles counters; otherwise they read 0.
module hazard_sequencer #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_sequencer_if.slave   hz
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  // A single-cycle mul/div never needs to hold the pipeline.
  localparam bit         MD_MULTI = (MD_LATENCY > 1);
  localparam logic [3:0] CNT_LOAD = MD_MULTI ? 4'(MD_LATENCY - 2) : 4'd0;

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic       md_stall;
  logic       lw_stall;
  logic       pc_flush;
  logic       rs_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      cnt_reg   <= 4'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (hz.MdStartE && MD_MULTI) begin
            state_reg <= MD_WAIT;
            cnt_reg   <= CNT_LOAD;
          end
        end
        MD_WAIT: begin
          // cnt==0 is the completion cycle: EX result leaves this cycle.
          if (cnt_reg == 4'd0) begin
            state_reg <= RUN;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= RUN;
          cnt_reg   <= 4'd0;
        end
      endcase
    end
  end

  assign rs_match = (hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D);

  always_comb begin
    md_stall = 1'b0;
    lw_stall = 1'b0;
    pc_flush = 1'b0;
    if (!rst) begin
      md_stall = ((state_reg == RUN) && hz.MdStartE && MD_MULTI) ||
                 ((state_reg == MD_WAIT) && (cnt_reg != 4'd0));
      lw_stall = hz.LoadE && (hz.RdE != 5'd0) && rs_match;
      pc_flush = hz.PCSrcE;
    end
  end

  // While a mul/div owns EX, load-use and branch requests belong to a younger instruction.
  assign hz.StallF = md_stall | lw_stall;
  assign hz.StallD = md_stall | lw_stall;
  assign hz.StallE = md_stall;
  assign hz.FlushM = md_stall;
  assign hz.FlushD = ~md_stall & pc_flush;
  assign hz.FlushE = ~md_stall & (lw_stall | pc_flush);
  assign hz.MdBusy = md_stall;

`ifdef HAZARD_PERF_EN
  logic [1:0]       perf_event;
  logic [CNT_W-1:0] perf_cnt_reg [2];

  assign perf_event[0] = hz.StallF;
  assign perf_event[1] = hz.FlushD | hz.FlushE;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      logic [CNT_W-1:0] perf_cnt_next;

      // Saturate instead of wrapping so long runs still read as "at least max".
      always_comb begin
        perf_cnt_next = perf_cnt_reg[gi];
        if (perf_event[gi] && (perf_cnt_reg[gi] != {CNT_W{1'b1}})) begin
          perf_cnt_next = perf_cnt_reg[gi] + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          perf_cnt_reg[gi] <= {CNT_W{1'b0}};
        end else begin
          perf_cnt_reg[gi] <= perf_cnt_next;
        end
      end
    end
  endgenerate

  assign hz.StallCycles = perf_cnt_reg[0];
  assign hz.FlushCycles = perf_cnt_reg[1];
`else
  assign hz.StallCycles = {CNT_W{1'b0}};
  assign hz.FlushCycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: per-cycle expectations queued at drive time, popped and compared at negedge.
// Covers reset masking, mul/div windows, load-use, branch flush, priorities, reset mid-op and counter saturation.
module tb_hazard_sequencer;
  localparam int MD_LAT  = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  hazard_sequencer_if #(.CNT_W(CNT_W)) hz ();

  hazard_sequencer #(
    .MD_LATENCY(MD_LAT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]       flags;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    string            name;
  } exp_t;

  exp_t q[$];
  int   total;
  int   bad;

  // Reference model state: remaining stall cycles after the current one and a pending completion gap.
  int md_left;
  bit md_gap;
  int sc_m;
  int fc_m;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // {StallF,StallD,StallE,FlushD,FlushE,FlushM,MdBusy}
  function automatic logic [6:0] calc_flags(input bit r, input bit md, input bit lw, input bit pc);
    if (r) return 7'b0;
    if (md) return 7'b1110011;
    return {lw, lw, 1'b0, pc, lw | pc, 1'b0, 1'b0};
  endfunction

  task automatic step(input string name, input bit r, input bit ld, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2, input bit pc, input bit md);
    exp_t e;
    bit   md_now;
    bit   lw;
    logic [6:0] obs;
    exp_t got;
    @(posedge clk);
    #1;
    rst         = r;
    hz.LoadE    = ld;
    hz.RdE      = rd;
    hz.Rs1D     = r1;
    hz.Rs2D     = r2;
    hz.PCSrcE   = pc;
    hz.MdStartE = md;

    md_now = 1'b0;
    if (r) begin
      md_left = 0;
      md_gap  = 1'b0;
    end else if (md_left > 0) begin
      md_now  = 1'b1;
      md_left = md_left - 1;
      if (md_left == 0) md_gap = 1'b1;
    end else if (md_gap) begin
      md_gap = 1'b0;
    end else if (md && MD_LAT > 1) begin
      md_now  = 1'b1;
      md_left = MD_LAT - 2;
      if (md_left == 0) md_gap = 1'b1;
    end
    lw = ld && (rd != 5'd0) && ((rd == r1) || (rd == r2));

    e.flags = calc_flags(r, md_now, lw, pc);
`ifdef HAZARD_PERF_EN
    e.sc = CNT_W'(sc_m);
    e.fc = CNT_W'(fc_m);
`else
    e.sc = '0;
    e.fc = '0;
`endif
    e.name = name;
    q.push_back(e);

    if (r) begin
      sc_m = 0;
      fc_m = 0;
    end else begin
      if (e.flags[6] && sc_m < CNT_MAX) sc_m++;
      if ((e.flags[3] || e.flags[2]) && fc_m < CNT_MAX) fc_m++;
    end

    @(negedge clk);
    obs = {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM, hz.MdBusy};
    got = q.pop_front();
    check_val({got.name, "_flags"}, 32'(obs), 32'(got.flags));
    check_val({got.name, "_stallcnt"}, 32'(hz.StallCycles), 32'(got.sc));
    check_val({got.name, "_flushcnt"}, 32'(hz.FlushCycles), 32'(got.fc));
    $display("cyc %s rst=%0b ld=%0b rd=%0d rs1=%0d rs2=%0d pc=%0b md=%0b -> flags=%b sc=%0d fc=%0d",
             got.name, r, ld, rd, r1, r2, pc, md, obs, hz.StallCycles, hz.FlushCycles);
  endtask

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++) step(name, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    md_left = 0;
    md_gap = 1'b0;
    sc_m = 0;
    fc_m = 0;
    rst = 1'b1;
    hz.LoadE = 1'b0;
    hz.RdE = 5'd0;
    hz.Rs1D = 5'd0;
    hz.Rs2D = 5'd0;
    hz.PCSrcE = 1'b0;
    hz.MdStartE = 1'b0;

    step("rst_mask", 1, 1, 5'd5, 5'd5, 5'd0, 1, 1);
    step("rst_mask", 1, 1, 5'd5, 5'd5, 5'd0, 1, 1);
    idle("post_rst", 2);

    step("md_start", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    idle("md_wait", 4);

    step("lw_rs2", 0, 1, 5'd7, 5'd1, 5'd7, 0, 0);
    step("lw_x0", 0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
    step("lw_nomatch", 0, 1, 5'd9, 5'd1, 5'd2, 0, 0);
    step("branch", 0, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    step("br_lw", 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);

    // mul/div masks load-use and branch until its completion cycle
    for (int i = 0; i < 4; i++) step("md_mask", 0, 1, 5'd4, 5'd4, 5'd0, 1, 1);
    idle("md_mask_end", 2);

    step("md_rst", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    step("md_rst_pulse", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    idle("md_rst_after", 3);

    for (int i = 0; i < 6; i++) step("md_b2b", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    idle("md_b2b_end", 3);

    step("perf_rst", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("perf_lw", 0, 1, 5'd12, 5'd12, 5'd0, 0, 0);
      idle("perf_gap", 1);
    end
    idle("perf_end", 2);

    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(0, 60) == 0),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
